// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty cycle (0-100 %) of an asynchronous PWM line.
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   pwm_in        : asynchronous PWM input, synchronised internally
//   duty_percent  : last measured duty, 0-100 (100 only on a stuck-high loss)
//   high_cycles   : last measured high time in clk cycles
//   period_cycles : last measured period in clk cycles
//   duty_valid    : one-cycle pulse when the three outputs above change
//   signal_lost   : high while no valid period is being measured
module pwm_capture #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 131071
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [6:0]       duty_percent,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] period_cycles,
    output logic             duty_valid,
    output logic             signal_lost
);
    localparam int NW = CNT_W + 7;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t            state, state_nxt;
    logic              s1, s2, s3;
    logic              rise, fall, timeout, start, ge;
    logic [CNT_W-1:0]  hi_cnt, lo_cnt, idle_cnt, per_now, hi_op, per_op;
    logic [NW-1:0]     rem, dvs;
    logic [5:0]        quo;
    logic [2:0]        step;
    logic              busy;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign per_now = hi_cnt + lo_cnt;
    assign timeout = (state != IDLE) && (idle_cnt == CNT_W'(TIMEOUT - 1));
    // A rise is only accepted when the previous division has fully reported,
    // which makes 9 cycles the shortest period that is ever reported.
    assign start   = (state == LOW) && rise && !timeout && !busy && !duty_valid;
    assign ge      = rem >= dvs;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = timeout                     ? IDLE :
                    (state == IDLE && rise)     ? HIGH :
                    (state == HIGH && fall)     ? LOW  :
                    (state == LOW  && rise)     ? HIGH : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {s1, s2, s3} <= '0;
        else        {s1, s2, s3} <= {pwm_in, s1, s2};

    // The edge-recognition cycle counts as the first cycle of the new phase.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            idle_cnt <= '0;
        end else begin
            idle_cnt <= (rise | fall) ? '0 :
                        (idle_cnt == CNT_W'(TIMEOUT - 1)) ? idle_cnt : idle_cnt + CNT_W'(1);
            hi_cnt   <= (rise && state != HIGH) ? CNT_W'(1) :
                        (state == HIGH && !fall) ? hi_cnt + CNT_W'(1) : hi_cnt;
            lo_cnt   <= (state == HIGH && fall) ? CNT_W'(1) :
                        (state == LOW) ? lo_cnt + CNT_W'(1) : lo_cnt;
        end

    // Restoring divider: the divisor starts at period<<6 and shifts right,
    // producing one quotient bit per cycle, MSB first, over 7 cycles.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy   <= 1'b0;
            rem    <= '0;
            dvs    <= '0;
            quo    <= '0;
            step   <= '0;
            hi_op  <= '0;
            per_op <= '0;
        end else if (timeout) begin
            busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            rem    <= NW'(hi_cnt) * NW'(7'd100);
            dvs    <= NW'(per_now) << 6;
            step   <= '0;
            hi_op  <= hi_cnt;
            per_op <= per_now;
        end else if (busy) begin
            rem  <= ge ? rem - dvs : rem;
            dvs  <= dvs >> 1;
            quo  <= {quo[4:0], ge};
            step <= step + 3'd1;
            busy <= step != 3'd6;
        end

    // Timeout has priority over a completing division.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            duty_percent  <= '0;
            high_cycles   <= '0;
            period_cycles <= '0;
            duty_valid    <= 1'b0;
            signal_lost   <= 1'b1;
        end else begin
            duty_valid <= 1'b0;
            if (timeout) begin
                duty_percent  <= s2 ? 7'd100 : 7'd0;
                high_cycles   <= '0;
                period_cycles <= '0;
                duty_valid    <= 1'b1;
                signal_lost   <= 1'b1;
            end else if (busy && step == 3'd6) begin
                duty_percent  <= {quo, ge};
                high_cycles   <= hi_op;
                period_cycles <= per_op;
                duty_valid    <= 1'b1;
                signal_lost   <= 1'b0;
            end
        end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed checks of pwm_capture against a phase-level reference model.
module tb_pwm_capture;
    localparam int CNT_W = 20;
    localparam int TMO   = 1000;

    typedef struct packed {
        int               t;
        logic [6:0]       d;
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] p;
        logic             l;
    } rep_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             pwm_in = 1'b0;
    logic [6:0]       duty_percent;
    logic [CNT_W-1:0] high_cycles, period_cycles;
    logic             duty_valid, signal_lost;

    rep_t obs_q[$], exp_q[$];
    int   ph[$];
    int   cyc = 0;
    bit   rec = 1'b0;
    int   n_chk = 0, n_fail = 0;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .duty_percent(duty_percent), .high_cycles(high_cycles), .period_cycles(period_cycles),
        .duty_valid(duty_valid), .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rec && duty_valid) obs_q.push_back('{cyc, duty_percent, high_cycles, period_cycles, signal_lost});

    task automatic do_reset();
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference: phases alternate high/low starting high; each drive-cycle level is seen as
    // an edge 2 cycles later. A rise after a complete high+low reports 8 cycles later unless
    // the previous accepted rise was fewer than 9 cycles before. TMO cycles without an edge
    // while measuring reports a loss one cycle later.
    task automatic model(input int t0, input int t_end);
        int e, nxt, pr, fl, dv;
        bit armed, fell, lvl;
        rep_t r;
        e = t0 + 2; pr = 0; fl = 0; dv = -1000; armed = 0; fell = 0;
        for (int k = 0; k < ph.size(); k++) begin
            lvl = (k % 2 == 0);
            nxt = e + ph[k];
            if (lvl) begin
                if (armed && fell && e - dv >= 9) begin
                    r.t = e + 8; r.d = 7'((fl - pr) * 100 / (e - pr));
                    r.h = CNT_W'(fl - pr); r.p = CNT_W'(e - pr); r.l = 1'b0;
                    exp_q.push_back(r);
                    dv = e;
                end
                armed = 1; fell = 0; pr = e;
            end else if (armed) begin
                fell = 1; fl = e;
            end
            if (armed && (k == ph.size() - 1 || nxt > e + TMO)) begin
                r.t = e + TMO + 1; r.d = lvl ? 7'd100 : 7'd0; r.h = '0; r.p = '0; r.l = 1'b1;
                exp_q.push_back(r);
                armed = 0;
            end
            e = nxt;
        end
        while (exp_q.size() > 0 && exp_q[$].t > t_end) void'(exp_q.pop_back());
    endtask

    task automatic run_phases();
        int t0, tot;
        tot = 0;
        obs_q.delete();
        exp_q.delete();
        @(posedge clk);
        rec = 1'b1;
        @(negedge clk);
        t0 = cyc;
        foreach (ph[k]) for (int j = 0; j < ph[k]; j++) begin
            pwm_in = (k % 2 == 0);
            tot++;
            @(negedge clk);
        end
        repeat (11) @(negedge clk);
        @(posedge clk);
        rec = 1'b0;
        model(t0, t0 + tot + 11);
    endtask

    task automatic test_reset();
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        n_chk += 5;
        if (duty_percent !== 7'd0) begin n_fail++; $display("FAIL reset duty_percent: got %0d want 0", duty_percent); end
        if (high_cycles !== '0)    begin n_fail++; $display("FAIL reset high_cycles: got %0d want 0", high_cycles); end
        if (period_cycles !== '0)  begin n_fail++; $display("FAIL reset period_cycles: got %0d want 0", period_cycles); end
        if (duty_valid !== 1'b0)   begin n_fail++; $display("FAIL reset duty_valid: got %b want 0", duty_valid); end
        if (signal_lost !== 1'b1)  begin n_fail++; $display("FAIL reset signal_lost: got %b want 1", signal_lost); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        rep_t o;
        do_reset();
        ph = '{30, 70, 30, 70, 30, 70, 30, 70, 30, 20};
        run_phases();
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic count: got %0d reports want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = (i < obs_q.size()) ? obs_q[i] : rep_t'(0);
            n_chk++;
            if (o !== exp_q[i]) begin n_fail++; $display("FAIL basic report %0d: got t=%0d duty=%0d high=%0d period=%0d lost=%0b want t=%0d duty=%0d high=%0d period=%0d lost=%0b", i, o.t, o.d, o.h, o.p, o.l, exp_q[i].t, exp_q[i].d, exp_q[i].h, exp_q[i].p, exp_q[i].l); end
        end
        n_chk += 4;
        if (duty_percent !== 7'd30)    begin n_fail++; $display("FAIL basic hold duty: got %0d want 30", duty_percent); end
        if (high_cycles !== 20'd30)    begin n_fail++; $display("FAIL basic hold high: got %0d want 30", high_cycles); end
        if (period_cycles !== 20'd100) begin n_fail++; $display("FAIL basic hold period: got %0d want 100", period_cycles); end
        if (signal_lost !== 1'b0)      begin n_fail++; $display("FAIL basic hold lost: got %b want 0", signal_lost); end
    endtask

    task automatic test_truncation();
        rep_t o;
        do_reset();
        ph = '{1, 999, 999, 1, 20, 30};
        run_phases();
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL trunc count: got %0d reports want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = (i < obs_q.size()) ? obs_q[i] : rep_t'(0);
            n_chk++;
            if (o !== exp_q[i]) begin n_fail++; $display("FAIL trunc report %0d: got t=%0d duty=%0d high=%0d period=%0d lost=%0b want t=%0d duty=%0d high=%0d period=%0d lost=%0b", i, o.t, o.d, o.h, o.p, o.l, exp_q[i].t, exp_q[i].d, exp_q[i].h, exp_q[i].p, exp_q[i].l); end
        end
        n_chk++;
        if (duty_percent !== 7'd99) begin n_fail++; $display("FAIL trunc final duty: got %0d want 99", duty_percent); end
    endtask

    task automatic test_stuck_high();
        rep_t o;
        do_reset();
        ph = '{1500};
        run_phases();
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stuck_high count: got %0d reports want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = (i < obs_q.size()) ? obs_q[i] : rep_t'(0);
            n_chk++;
            if (o !== exp_q[i]) begin n_fail++; $display("FAIL stuck_high report %0d: got t=%0d duty=%0d high=%0d period=%0d lost=%0b want t=%0d duty=%0d high=%0d period=%0d lost=%0b", i, o.t, o.d, o.h, o.p, o.l, exp_q[i].t, exp_q[i].d, exp_q[i].h, exp_q[i].p, exp_q[i].l); end
        end
        n_chk += 2;
        if (signal_lost !== 1'b1)    begin n_fail++; $display("FAIL stuck_high lost: got %b want 1", signal_lost); end
        if (duty_percent !== 7'd100) begin n_fail++; $display("FAIL stuck_high duty: got %0d want 100", duty_percent); end
    endtask

    task automatic test_stuck_low();
        rep_t o;
        do_reset();
        ph = '{40, 1500, 100, 100, 100, 100, 100, 30};
        run_phases();
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stuck_low count: got %0d reports want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = (i < obs_q.size()) ? obs_q[i] : rep_t'(0);
            n_chk++;
            if (o !== exp_q[i]) begin n_fail++; $display("FAIL stuck_low report %0d: got t=%0d duty=%0d high=%0d period=%0d lost=%0b want t=%0d duty=%0d high=%0d period=%0d lost=%0b", i, o.t, o.d, o.h, o.p, o.l, exp_q[i].t, exp_q[i].d, exp_q[i].h, exp_q[i].p, exp_q[i].l); end
        end
        n_chk += 2;
        if (signal_lost !== 1'b0)   begin n_fail++; $display("FAIL stuck_low recovered lost: got %b want 0", signal_lost); end
        if (duty_percent !== 7'd50) begin n_fail++; $display("FAIL stuck_low recovered duty: got %0d want 50", duty_percent); end
    endtask

    task automatic test_short_period();
        rep_t o;
        do_reset();
        ph = '{30, 70, 3, 3, 50, 50, 4, 5, 4, 4, 50, 50, 10};
        run_phases();
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL short count: got %0d reports want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = (i < obs_q.size()) ? obs_q[i] : rep_t'(0);
            n_chk++;
            if (o !== exp_q[i]) begin n_fail++; $display("FAIL short report %0d: got t=%0d duty=%0d high=%0d period=%0d lost=%0b want t=%0d duty=%0d high=%0d period=%0d lost=%0b", i, o.t, o.d, o.h, o.p, o.l, exp_q[i].t, exp_q[i].d, exp_q[i].h, exp_q[i].p, exp_q[i].l); end
        end
    endtask

    task automatic test_random();
        rep_t o;
        do_reset();
        ph.delete();
        for (int k = 0; k < 41; k++)
            ph.push_back(($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 8)) : int'($urandom_range(9, 250)));
        ph.push_back(1100);
        run_phases();
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random count: got %0d reports want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = (i < obs_q.size()) ? obs_q[i] : rep_t'(0);
            n_chk++;
            if (o !== exp_q[i]) begin n_fail++; $display("FAIL random report %0d: got t=%0d duty=%0d high=%0d period=%0d lost=%0b want t=%0d duty=%0d high=%0d period=%0d lost=%0b", i, o.t, o.d, o.h, o.p, o.l, exp_q[i].t, exp_q[i].d, exp_q[i].h, exp_q[i].p, exp_q[i].l); end
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        do_reset();
        for (int j = 0; j < 200; j++) begin
            pwm_in = ((j % 100) < 30);
            @(negedge clk);
        end
        pwm_in = 1'b1;
        repeat (6) @(negedge clk);
        n_chk++;
        if (duty_percent !== 7'd30) begin n_fail++; $display("FAIL async pre-reset duty: got %0d want 30", duty_percent); end
        rst_n = 1'b0;
        #1;
        n_chk += 5;
        if (duty_percent !== 7'd0) begin n_fail++; $display("FAIL async duty_percent: got %0d want 0", duty_percent); end
        if (high_cycles !== '0)    begin n_fail++; $display("FAIL async high_cycles: got %0d want 0", high_cycles); end
        if (period_cycles !== '0)  begin n_fail++; $display("FAIL async period_cycles: got %0d want 0", period_cycles); end
        if (duty_valid !== 1'b0)   begin n_fail++; $display("FAIL async duty_valid: got %b want 0", duty_valid); end
        if (signal_lost !== 1'b1)  begin n_fail++; $display("FAIL async signal_lost: got %b want 1", signal_lost); end
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (duty_valid) pulses++;
        end
        n_chk += 2;
        if (pulses != 0)          begin n_fail++; $display("FAIL async post-release pulses: got %0d want 0", pulses); end
        if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL async post-release lost: got %b want 1", signal_lost); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_stuck_high();
        test_stuck_low();
        test_short_period();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
